// File: rtl/roll_removal_engine.sv
// Roll removal engine: loads a WIDTH x DEPTH occupancy grid row by row, then repeatedly strips
// rolls with fewer than THRESH occupied neighbours, one row per cycle, until stable (or once).
// Optional macro RRE_GRID_READBACK_EN adds a combinational current-grid row readback port.
module roll_removal_engine #(
  parameter int WIDTH  = 10,
  parameter int DEPTH  = 10,
  parameter int THRESH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic             row_valid,
  input  logic [WIDTH-1:0] row_data,
  output logic             row_ready,
  output logic [31:0]      total_removed,
  output logic [15:0]      passes,
  output logic             busy,
  output logic             done
`ifdef RRE_GRID_READBACK_EN
  ,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
`endif
);

  typedef enum logic [2:0] {IDLE, LOAD, SCAN, COMMIT, DONE} state_t;

  // Neighbour counts never exceed 8, so a threshold above 9 behaves exactly like 9.
  localparam logic [4:0]    TH   = (THRESH > 9) ? 5'd9 : 5'(THRESH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t           state;
  logic             mode_q;
  logic [AW-1:0]    row_idx;
  logic [31:0]      pass_cnt;
  logic [WIDTH-1:0] cur_grid [DEPTH];
  logic [WIDTH-1:0] nxt_grid [DEPTH];

  logic [WIDTH-1:0] row_up, row_mid, row_dn, acc_row;
  logic [WIDTH+1:0] up_p, mid_p, dn_p;
  logic [4:0]       nbr;
  logic [31:0]      acc_cnt;
  logic             load_we, scan_we, commit_copy;

  // Rows above/below the grid read as empty; pad columns so off-grid neighbours are empty too.
  always_comb begin
    row_mid = cur_grid[row_idx];
    row_up  = (row_idx == '0)  ? '0 : cur_grid[row_idx - 1'b1];
    row_dn  = (row_idx == LAST) ? '0 : cur_grid[row_idx + 1'b1];
    up_p    = {1'b0, row_up, 1'b0};
    mid_p   = {1'b0, row_mid, 1'b0};
    dn_p    = {1'b0, row_dn, 1'b0};
  end

  // Accessible rolls in the current row, evaluated against the frozen current grid.
  always_comb begin
    acc_row = '0;
    acc_cnt = '0;
    nbr     = '0;
    for (int c = 0; c < WIDTH; c++) begin
      nbr = 5'(up_p[c]) + 5'(up_p[c+1]) + 5'(up_p[c+2]) +
            5'(mid_p[c]) + 5'(mid_p[c+2]) +
            5'(dn_p[c]) + 5'(dn_p[c+1]) + 5'(dn_p[c+2]);
      acc_row[c] = row_mid[c] && (nbr < TH);
      acc_cnt    = acc_cnt + {31'b0, acc_row[c]};
    end
  end

  assign load_we     = (state == LOAD) && row_valid;
  assign scan_we     = (state == SCAN);
  assign commit_copy = (state == COMMIT) && mode_q && (pass_cnt != '0);

  // Grid storage: loaded beats, per-row survivors, and the end-of-pass snapshot swap.
  always_ff @(posedge clk) begin
    if (load_we) cur_grid[row_idx] <= row_data;
    if (scan_we) nxt_grid[row_idx] <= row_mid & ~acc_row;
    if (commit_copy) begin
      for (int r = 0; r < DEPTH; r++) cur_grid[r] <= nxt_grid[r];
    end
  end

  // Job control FSM with registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      mode_q        <= 1'b0;
      row_idx       <= '0;
      pass_cnt      <= '0;
      total_removed <= '0;
      passes        <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      row_ready     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            total_removed <= '0;
            passes        <= '0;
            done          <= 1'b0;
            busy          <= 1'b1;
            mode_q        <= mode;
            row_idx       <= '0;
            row_ready     <= 1'b1;
            state         <= LOAD;
          end
        end
        LOAD: begin
          if (row_valid) begin
            if (row_idx == LAST) begin
              row_idx   <= '0;
              row_ready <= 1'b0;
              pass_cnt  <= '0;
              state     <= SCAN;
            end else begin
              row_idx <= row_idx + 1'b1;
            end
          end
        end
        SCAN: begin
          total_removed <= total_removed + acc_cnt;
          pass_cnt      <= pass_cnt + acc_cnt;
          if (row_idx == LAST) state <= COMMIT;
          else                 row_idx <= row_idx + 1'b1;
        end
        COMMIT: begin
          if (pass_cnt != '0 && passes != 16'hFFFF) passes <= passes + 16'd1;
          if (!mode_q || pass_cnt == '0) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            row_idx  <= '0;
            pass_cnt <= '0;
            state    <= SCAN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RRE_GRID_READBACK_EN
  assign rd_data = cur_grid[rd_addr];
`endif

endmodule

// File: tb/tb_roll_removal_engine.sv
// Testbench for roll_removal_engine: directed job table on a 10x10 instance plus a 3x3 instance,
// with hand-written sequences for reset-mid-scan, held done and a stray start.
module tb_roll_removal_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start_a, start_b, mode, row_valid;
  logic [9:0]  row_data;
  logic        a_rdy, a_busy, a_done, b_rdy, b_busy, b_done;
  logic [31:0] a_tot, b_tot;
  logic [15:0] a_pas, b_pas;

  roll_removal_engine #(.WIDTH(10), .DEPTH(10), .THRESH(4)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .mode(mode), .row_valid(row_valid),
    .row_data(row_data), .row_ready(a_rdy), .total_removed(a_tot), .passes(a_pas),
    .busy(a_busy), .done(a_done)
  );

  roll_removal_engine #(.WIDTH(3), .DEPTH(3), .THRESH(4)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .mode(mode), .row_valid(row_valid),
    .row_data(row_data[2:0]), .row_ready(b_rdy), .total_removed(b_tot), .passes(b_pas),
    .busy(b_busy), .done(b_done)
  );

  int errors = 0;
  int checks = 0;

  logic [9:0] grid [10];
  string ex_s [10];

  typedef struct {
    int g;     // 0 = example grid, 1 = empty grid
    bit m;     // mode
    bit rv;    // randomised row_valid
    bit st;    // stray start during SCAN
    int et;    // expected total_removed
    int ep;    // expected passes
    int ec;    // expected cycles from accept to done, -1 = not checked
  } vec_t;

  vec_t tbl [5];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [9:0] row_of(input string s);
    logic [9:0] r;
    r = '0;
    for (int i = 0; i < 10; i++) if (s[i] == 8'h40) r[i] = 1'b1;
    return r;
  endfunction

  task automatic set_grid(input int g);
    for (int r = 0; r < 10; r++) grid[r] = (g == 0) ? row_of(ex_s[r]) : 10'd0;
  endtask

  // Start a job on one instance, feed rows whenever row_ready, count cycles until done.
  task automatic run_job(input int which, input bit m, input bit rand_v, input bit stray,
                         output int cyc, output bit timeout);
    int  depth;
    int  idx;
    int  n;
    bit  v;
    bit  rdy;
    bit  sent;
    depth = (which == 1) ? 3 : 10;
    idx = 0; n = 0; sent = 0; timeout = 1;
    @(negedge clk);
    mode = m;
    if (which == 1) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      start_a = 1'b0;
      start_b = 1'b0;
      rdy = (which == 1) ? b_rdy : a_rdy;
      if (n == 0) begin
        check("busy_after_start", (which == 1) ? b_busy : a_busy, 1);
        check("ready_in_load", rdy, 1);
      end
      if ((which == 1) ? b_done : a_done) begin
        timeout = 0;
        break;
      end
      if (stray && !sent && n > depth && !rdy) begin
        if (which == 1) start_b = 1'b1; else start_a = 1'b1;
        sent = 1;
      end
      v = rand_v ? 1'($urandom_range(0, 1)) : 1'b1;
      row_valid = v && (idx < depth);
      row_data  = (idx < depth) ? grid[idx] : 10'd0;
      @(posedge clk);
      n++;
      if (row_valid && rdy) idx++;
    end
    row_valid = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    cyc = n;
  endtask

  initial begin
    int  cyc;
    bit  to;
    logic [31:0] held_tot;

    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; mode = 1'b0;
    row_valid = 1'b0; row_data = '0;
    ex_s = '{"..@@.@@@@.", "@@@.@.@.@@", "@@@@@.@.@@", "@.@@@@..@.", "@@.@@@@.@@",
             ".@@@@@@@.@", ".@.@.@.@@@", "@.@@@.@@@@", ".@@@@@@@@.", "@.@.@@@.@."};

    tbl[0] = '{g:0, m:1'b1, rv:1'b0, st:1'b0, et:43, ep:9, ec:120};
    tbl[1] = '{g:0, m:1'b0, rv:1'b0, st:1'b0, et:13, ep:1, ec:21};
    tbl[2] = '{g:1, m:1'b1, rv:1'b0, st:1'b0, et:0,  ep:0, ec:21};
    tbl[3] = '{g:0, m:1'b1, rv:1'b1, st:1'b1, et:43, ep:9, ec:-1};
    tbl[4] = '{g:0, m:1'b0, rv:1'b0, st:1'b1, et:13, ep:1, ec:21};

    repeat (3) @(posedge clk);
    #1;
    check("rst_total", a_tot, 0);
    check("rst_passes", a_pas, 0);
    check("rst_busy", a_busy, 0);
    check("rst_done", a_done, 0);
    check("rst_ready", a_rdy, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_ready", a_rdy, 0);

    // Table of whole jobs on the 10x10 instance
    for (int t = 0; t < 5; t++) begin
      set_grid(tbl[t].g);
      run_job(0, tbl[t].m, tbl[t].rv, tbl[t].st, cyc, to);
      check($sformatf("v%0d_timeout", t), to, 0);
      check($sformatf("v%0d_total", t), a_tot, tbl[t].et);
      check($sformatf("v%0d_passes", t), a_pas, tbl[t].ep);
      check($sformatf("v%0d_busy", t), a_busy, 0);
      if (tbl[t].ec >= 0) check($sformatf("v%0d_cycles", t), cyc, tbl[t].ec);
    end

    // done is a level held until the next start, results stay stable
    held_tot = a_tot;
    repeat (5) @(negedge clk);
    check("done_held", a_done, 1);
    check("total_held", a_tot, held_tot);
    check("ready_in_done", a_rdy, 0);

    // 3x3 all rolls: corners, then edges, then centre
    for (int r = 0; r < 10; r++) grid[r] = (r < 3) ? 10'h007 : 10'h000;
    run_job(1, 1'b1, 1'b0, 1'b0, cyc, to);
    check("g3_timeout", to, 0);
    check("g3_total", b_tot, 9);
    check("g3_passes", b_pas, 3);
    check("g3_cycles", cyc, 19);

    // Reset in the middle of SCAN abandons the job
    set_grid(0);
    @(negedge clk);
    mode = 1'b1;
    start_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_a = 1'b0;
    row_valid = 1'b1;
    for (int r = 0; r < 10; r++) begin
      row_data = grid[r];
      @(posedge clk);
      #1;
    end
    row_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("pre_rst_nonzero", (a_tot != 0), 1);
    check("pre_rst_busy", a_busy, 1);
    rst = 1'b1;
    #1;
    check("midrst_total", a_tot, 0);
    check("midrst_passes", a_pas, 0);
    check("midrst_busy", a_busy, 0);
    check("midrst_done", a_done, 0);
    check("midrst_ready", a_rdy, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("post_rst_idle", a_busy, 0);
    run_job(0, 1'b1, 1'b0, 1'b0, cyc, to);
    check("after_rst_timeout", to, 0);
    check("after_rst_total", a_tot, 43);
    check("after_rst_passes", a_pas, 9);
    check("after_rst_cycles", cyc, 120);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/roll_removal_engine.md
ROLL_REMOVAL_ENGINE -- requirements
Module: roll_removal_engine

Interface
REQ-001 The block SHALL have parameter WIDTH, default 10, grid columns (2..64).
REQ-002 The block SHALL have parameter DEPTH, default 10, grid rows (2..64).
REQ-003 The block SHALL have parameter THRESH, default 4, a roll is accessible when its occupied-neighbour count (8-neighbourhood, off-grid = empty) is < THRESH.
REQ-004 Port clk  input  1  the block's only clock; all logic on rising edge.
REQ-005 Port rst  input  1  reset, asynchronous, active-high.
REQ-006 Port start  input  1  one-cycle request to begin a job.
REQ-007 Port mode  input  1  0 = single pass (count accessible rolls only), 1 = iterate until stable; sampled on accepted start.
REQ-008 Port row_valid  input  1  row beat valid.
REQ-009 Port row_data  input  WIDTH  one grid row, bit c = column c (column 0 leftmost), 1 = roll.
REQ-010 Port row_ready  output  1  block accepts a row beat this cycle.
REQ-011 Port total_removed  output  32  rolls removed (mode 1) or accessible (mode 0).
REQ-012 Port passes  output  16  count of scan passes that removed at least one roll.
REQ-013 Port busy  output  1  high from accepted start until done rises.
REQ-014 Port done  output  1  level, high when result valid, held until next accepted start.

Function
REQ-015 FSM states SHALL be IDLE, LOAD, SCAN, COMMIT, DONE.
REQ-016 start SHALL be accepted only in IDLE or DONE; otherwise ignored.
REQ-017 Accepted start SHALL clear total_removed, passes, done, set busy, latch mode, enter LOAD next cycle.
REQ-018 In LOAD row_ready SHALL be 1; a beat transfers when row_valid && row_ready; rows fill 0..DEPTH-1 in order.
REQ-019 row_ready SHALL be 0 in all states except LOAD; row_valid outside LOAD is ignored.
REQ-020 After the DEPTH-th beat the FSM SHALL enter SCAN with row index 0.
REQ-021 SCAN SHALL evaluate one row per cycle against the frozen current grid, writing survivors into a next-grid buffer and adding that row's accessible count to total_removed.
REQ-022 After row DEPTH-1 the FSM SHALL enter COMMIT (1 cycle): if pass count nonzero, passes increments (saturating at 65535).
REQ-023 In COMMIT, if mode=0 or pass count is zero, FSM SHALL enter DONE; else next-grid copies to current grid and SCAN restarts at row 0.
REQ-024 Each pass SHALL take exactly DEPTH+1 cycles; done SHALL rise the cycle after the terminating COMMIT.
REQ-025 Removals within a pass SHALL be simultaneous (snapshot semantics), never greedy within a pass.
REQ-026 Empty grid SHALL finish after one pass with total_removed=0, passes=0.

Reset
REQ-027 rst SHALL asynchronously force IDLE; total_removed=0, passes=0, busy=0, done=0, row_ready=0; grid contents undefined.
REQ-028 rst asserted mid-LOAD or mid-SCAN SHALL abandon the job; a new start is required after release.

Configuration
REQ-029 Macro RRE_GRID_READBACK_EN: when defined, add ports rd_addr (input, clog2(DEPTH)) and rd_data (output, WIDTH) giving the current-grid row combinationally; valid for final grid while done=1.
REQ-030 Without RRE_GRID_READBACK_EN those ports SHALL not exist and behaviour is otherwise identical.

Verification
REQ-031 10x10 example grid (rows "..@@.@@@@.", "@@@.@.@.@@", "@@@@@.@.@@", "@.@@@@..@.", "@@.@@@@.@@", ".@@@@@@@.@", ".@.@.@.@@@", "@.@@@.@@@@", ".@@@@@@@@.", "@.@.@@@.@."), mode=1 -> total_removed=43, passes=9.
REQ-032 Same grid, mode=0 -> total_removed=13, passes=1, done 10 load + 11 cycles after start accept.
REQ-033 WIDTH=DEPTH=3, all rolls, mode=1 -> total_removed=9, passes=3 (4 corners, 4 edges, centre).
REQ-034 All-empty 10x10 grid, mode=1 -> total_removed=0, passes=0, done after one pass.
REQ-035 row_valid toggled randomly during LOAD, start pulsed during SCAN -> results identical to REQ-031, stray start ignored.
REQ-036 rst pulsed mid-SCAN -> outputs zero immediately, IDLE; subsequent full job gives REQ-031 result.
